// File: rtl/mem_lsu_pkg.sv
// Shared types for the MEM-stage load/store unit: FSM states, funct3 codes,
// access sizes and a funct3 -> size decoder.
package riscv_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } lsu_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } lsu_size_t;

  // funct3[1:0] carries the size for both loads and stores; 2'b11 is treated as a word.
  function automatic lsu_size_t f3_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return SZ_B;
      2'b01:   return SZ_H;
      default: return SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Data-memory request/grant/response bus between the LSU (master) and memory (slave).
interface mem_lsu_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              dmem_req;
  logic              dmem_we;
  logic [3:0]        dmem_be;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_gnt;
  logic              dmem_rvalid;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_err;

  modport master (
    output dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata, dmem_err
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata, dmem_err
  );
endinterface

// File: rtl/mem_lsu_load_align.sv
// Load formatter: shifts the addressed lane down to bit 0, then sign- or
// zero-extends according to funct3.
module lsu_load_align
  import riscv_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);
  logic [31:0] shifted;

  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    result  = shifted;
    case (funct3)
      F3_LB:   result = {{24{shifted[7]}}, shifted[7:0]};
      F3_LBU:  result = {24'h0, shifted[7:0]};
      F3_LH:   result = {{16{shifted[15]}}, shifted[15:0]};
      F3_LHU:  result = {16'h0, shifted[15:0]};
      F3_LW:   result = shifted;
      default: result = shifted;
    endcase
  end
endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: one req/gnt/rvalid transaction per EX/MEM op.
// Define LSU_MISALIGN_CHECK_EN to trap misaligned halfword/word accesses.
module mem_lsu
  import riscv_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              flush,
  input  logic              pipe_advance,
  mem_lsu_if.master         dmem,
  output logic              lsu_stall,
  output logic [DATA_W-1:0] load_data,
  output logic              bus_err,
  output logic              misaligned
);
  lsu_state_t        state_q, state_d;
  logic              req_q, req_d, we_q, we_d;
  logic [3:0]        be_q, be_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, load_q, load_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        off_q, off_d;
  logic              done_q, done_d, discard_q, discard_d;
  logic              bus_err_q, bus_err_d, mis_q, mis_d;

  lsu_size_t         size;
  logic              issue, mis;
  logic [3:0]        st_be;
  logic [DATA_W-1:0] st_wdata;
  logic [1:0]        off;
  logic [DATA_W-1:0] aligned;

  assign size  = f3_size(funct3);
  assign issue = req_valid && !done_q && !flush;

`ifdef LSU_MISALIGN_CHECK_EN
  assign mis = (size == SZ_H && addr[0]) || (size == SZ_W && addr[1:0] != 2'b00);
`else
  assign mis = 1'b0;
`endif

  // Without the misalign trap, low address bits below the access size are simply dropped.
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = wdata;
    off      = 2'b00;
    case (size)
      SZ_B: begin
        st_be    = 4'b0001 << addr[1:0];
        st_wdata = {4{wdata[7:0]}};
        off      = addr[1:0];
      end
      SZ_H: begin
        st_be    = addr[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{wdata[15:0]}};
        off      = {addr[1], 1'b0};
      end
      default: ;
    endcase
  end

  lsu_load_align u_align (
    .rdata  (dmem.dmem_rdata),
    .offset (off_q),
    .funct3 (f3_q),
    .result (aligned)
  );

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    be_d      = be_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    f3_d      = f3_q;
    off_d     = off_q;
    load_d    = load_q;
    discard_d = discard_q;
    done_d    = done_q && !pipe_advance;
    bus_err_d = 1'b0;
    mis_d     = 1'b0;
    case (state_q)
      S_IDLE: if (issue) begin
        if (mis) begin
          mis_d  = 1'b1;
          load_d = '0;
          done_d = 1'b1;
        end else begin
          state_d = S_REQ;
          req_d   = 1'b1;
          we_d    = mem_write;
          be_d    = mem_write ? st_be : 4'b1111;
          addr_d  = {addr[ADDR_W-1:2], 2'b00};
          wdata_d = st_wdata;
          f3_d    = funct3;
          off_d   = off;
        end
      end
      S_REQ: begin
        if (flush) discard_d = 1'b1;
        if (dmem.dmem_gnt) begin
          req_d   = 1'b0;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (flush) discard_d = 1'b1;
        // A killed op still drains the bus, but must not touch pipeline-visible state.
        if (dmem.dmem_rvalid) begin
          state_d   = S_IDLE;
          discard_d = 1'b0;
          if (!(discard_q || flush)) begin
            done_d    = 1'b1;
            bus_err_d = dmem.dmem_err;
            if (!we_q) load_d = aligned;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      be_q      <= 4'b0000;
      addr_q    <= '0;
      wdata_q   <= '0;
      f3_q      <= 3'b000;
      off_q     <= 2'b00;
      load_q    <= '0;
      done_q    <= 1'b0;
      discard_q <= 1'b0;
      bus_err_q <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      we_q      <= we_d;
      be_q      <= be_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      f3_q      <= f3_d;
      off_q     <= off_d;
      load_q    <= load_d;
      done_q    <= done_d;
      discard_q <= discard_d;
      bus_err_q <= bus_err_d;
      mis_q     <= mis_d;
    end
  end

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_be    = be_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;

  assign lsu_stall  = (state_q != S_IDLE) || issue;
  assign load_data  = load_q;
  assign bus_err    = bus_err_q;
  assign misaligned = mis_q;
endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: directed scenarios plus randomized ops checked against a
// byte-addressed little-endian memory model.
module tb_mem_lsu;
  import riscv_pkg::*;

  logic        clk, rst_n, req_valid, mem_write, flush, pipe_advance;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, load_data;
  logic        lsu_stall, bus_err, misaligned;
  int          n_tests, n_fail;

  mem_lsu_if dmem ();

  mem_lsu dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .mem_write    (mem_write),
    .funct3       (funct3),
    .addr         (addr),
    .wdata        (wdata),
    .flush        (flush),
    .pipe_advance (pipe_advance),
    .dmem         (dmem),
    .lsu_stall    (lsu_stall),
    .load_data    (load_data),
    .bus_err      (bus_err),
    .misaligned   (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // bus-side memory (what the slave stores) and reference byte memory
  logic [31:0] bmem [16];
  logic [7:0]  rmem [64];

  typedef struct {
    int          stall_n;
    logic        saw_req, stable, timeout, we, mis, berr, done;
    logic [3:0]  be;
    logic [31:0] addr, wdata, ld;
  } res_t;

  function automatic void preload(input int idx, input logic [31:0] val);
    bmem[idx] = val;
    for (int k = 0; k < 4; k++) rmem[4*idx+k] = val[8*k +: 8];
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    int b;
    b = int'(a[5:0]);
    case (f3)
      3'b000:  return {{24{rmem[b][7]}}, rmem[b]};
      3'b100:  return {24'h0, rmem[b]};
      3'b001:  return {{16{rmem[b+1][7]}}, rmem[b+1], rmem[b]};
      3'b101:  return {16'h0, rmem[b+1], rmem[b]};
      default: return {rmem[b+3], rmem[b+2], rmem[b+1], rmem[b]};
    endcase
  endfunction

  function automatic void ref_store(input int sz, input logic [31:0] a, input logic [31:0] wd);
    int b;
    b = int'(a[5:0]);
    for (int k = 0; k < (1 << sz); k++) rmem[b+k] = wd[8*k +: 8];
  endfunction

  // Presents one op at posedge+1 and plays the slave with gd grant-wait and rd response-wait
  // cycles; returns at posedge+1 after the op has retired.
  task automatic run_op(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int gd, input int rd, input logic e,
                        input int flush_at, output res_t r);
    int g, rc;
    logic in_resp, fin;
    r = '{default: 0};
    r.stable = 1'b1;
    g = 0; rc = 0; in_resp = 1'b0; fin = 1'b0;
    req_valid = 1'b1; mem_write = w; funct3 = f3; addr = a; wdata = wd;
    for (int cyc = 0; cyc < 40 && !fin; cyc++) begin
      @(negedge clk);
      if (!lsu_stall) begin
        fin = 1'b1;
        r.mis = misaligned; r.berr = bus_err; r.ld = load_data; r.done = dut.done_q;
      end else begin
        r.stall_n++;
        if (dmem.dmem_req) begin
          if (!r.saw_req) begin
            r.saw_req = 1'b1; r.we = dmem.dmem_we; r.be = dmem.dmem_be;
            r.addr = dmem.dmem_addr; r.wdata = dmem.dmem_wdata;
          end else if ({dmem.dmem_we, dmem.dmem_be, dmem.dmem_addr, dmem.dmem_wdata}
                       != {r.we, r.be, r.addr, r.wdata}) r.stable = 1'b0;
          if (g == gd) begin dmem.dmem_gnt = 1'b1; in_resp = 1'b1; end
          else g++;
        end else if (in_resp) begin
          if (rc == rd) begin
            dmem.dmem_rvalid = 1'b1; dmem.dmem_err = e;
            dmem.dmem_rdata = bmem[r.addr[5:2]];
            if (r.we) for (int b = 0; b < 4; b++)
              if (r.be[b]) bmem[r.addr[5:2]][8*b +: 8] = r.wdata[8*b +: 8];
            in_resp = 1'b0;
          end else rc++;
        end
        if (cyc == flush_at) flush = 1'b1;
        @(posedge clk); #1;
        dmem.dmem_gnt = 1'b0; dmem.dmem_rvalid = 1'b0; dmem.dmem_err = 1'b0;
        if (flush) begin flush = 1'b0; req_valid = 1'b0; end
      end
    end
    r.timeout = !fin;
    if (r.timeout) begin
      n_tests++; n_fail++;
      $display("FAIL op_timeout: got stall still high after %0d cycles, want op to retire", r.stall_n);
    end
    pipe_advance = 1'b1;
    @(posedge clk); #1;
    pipe_advance = 1'b0; req_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_valid = 1'b0; mem_write = 1'b0; funct3 = 3'b000; addr = '0; wdata = '0;
    flush = 1'b0; pipe_advance = 1'b0;
    dmem.dmem_gnt = 1'b0; dmem.dmem_rvalid = 1'b0; dmem.dmem_rdata = '0; dmem.dmem_err = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({dmem.dmem_req, dmem.dmem_we, dmem.dmem_be} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 000000", {dmem.dmem_req, dmem.dmem_we, dmem.dmem_be});
    end
    n_tests++;
    if ({dmem.dmem_addr, dmem.dmem_wdata, load_data} !== 96'h0) begin
      n_fail++; $display("FAIL reset_data: got %h want 0", {dmem.dmem_addr, dmem.dmem_wdata, load_data});
    end
    n_tests++;
    if ({lsu_stall, bus_err, misaligned} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b want 000", {lsu_stall, bus_err, misaligned});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_lb;
    res_t r;
    preload(0, 32'h80FF_1234);
    run_op(1'b0, F3_LB, 32'h1003, 32'h0, 0, 0, 1'b0, -1, r);
    n_tests++;
    if (r.stall_n !== 3) begin n_fail++; $display("FAIL lb_stall: got %0d want 3", r.stall_n); end
    n_tests++;
    if ({r.we, r.be, r.addr} !== {1'b0, 4'b1111, 32'h1000}) begin
      n_fail++; $display("FAIL lb_bus: got we=%b be=%b addr=%h want we=0 be=1111 addr=00001000", r.we, r.be, r.addr);
    end
    n_tests++;
    if (r.ld !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_data: got %h want ffffff80", r.ld); end
  endtask

  task automatic test_sh;
    res_t r;
    run_op(1'b1, 3'b001, 32'h2002, 32'hABCD_5678, 0, 0, 1'b0, -1, r);
    n_tests++;
    if ({r.we, r.be, r.addr} !== {1'b1, 4'b1100, 32'h2000}) begin
      n_fail++; $display("FAIL sh_bus: got we=%b be=%b addr=%h want we=1 be=1100 addr=00002000", r.we, r.be, r.addr);
    end
    n_tests++;
    if (r.wdata !== 32'h5678_5678) begin n_fail++; $display("FAIL sh_wdata: got %h want 56785678", r.wdata); end
    n_tests++;
    if (r.ld !== 32'hFFFF_FF80 || r.stall_n !== 3) begin
      n_fail++; $display("FAIL sh_keep: got ld=%h stall=%0d want ld=ffffff80 stall=3", r.ld, r.stall_n);
    end
  endtask

  task automatic test_lw_gnt_delay;
    res_t r;
    preload(0, 32'h1357_2468);
    run_op(1'b0, F3_LW, 32'h1000, 32'h0, 3, 0, 1'b0, -1, r);
    n_tests++;
    if (r.stable !== 1'b1) begin n_fail++; $display("FAIL gnt_stable: got %b want 1", r.stable); end
    n_tests++;
    if (r.stall_n !== 6) begin n_fail++; $display("FAIL gnt_stall: got %0d want 6", r.stall_n); end
    n_tests++;
    if (r.ld !== 32'h1357_2468) begin n_fail++; $display("FAIL gnt_data: got %h want 13572468", r.ld); end
  endtask

  task automatic test_flush_resp;
    res_t r;
    preload(0, 32'hDEAD_BEEF);
    run_op(1'b0, F3_LW, 32'h1000, 32'h0, 0, 2, 1'b1, 2, r);
    n_tests++;
    if (r.ld !== 32'h1357_2468) begin n_fail++; $display("FAIL flush_data: got %h want 13572468", r.ld); end
    n_tests++;
    if ({r.done, r.berr} !== 2'b00) begin n_fail++; $display("FAIL flush_flags: got done,err=%b want 00", {r.done, r.berr}); end
    n_tests++;
    if (r.stall_n !== 5) begin n_fail++; $display("FAIL flush_stall: got %0d want 5", r.stall_n); end
  endtask

  task automatic test_bus_err;
    res_t r;
    preload(1, 32'h0BAD_F00D);
    run_op(1'b0, F3_LW, 32'h1004, 32'h0, 0, 0, 1'b1, -1, r);
    n_tests++;
    if ({r.berr, r.ld} !== {1'b1, 32'h0BAD_F00D}) begin
      n_fail++; $display("FAIL err_pulse: got err=%b ld=%h want err=1 ld=0badf00d", r.berr, r.ld);
    end
    @(negedge clk);
    n_tests++;
    if (bus_err !== 1'b0) begin n_fail++; $display("FAIL err_width: got %b want 0", bus_err); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    req_valid = 1'b1; mem_write = 1'b0; funct3 = F3_LW; addr = 32'h1000;
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (dmem.dmem_req !== 1'b1) begin n_fail++; $display("FAIL rstmid_req: got %b want 1", dmem.dmem_req); end
    rst_n = 1'b0; req_valid = 1'b0;
    #1;
    n_tests++;
    if (dmem.dmem_req !== 1'b0 || dut.state_q !== S_IDLE) begin
      n_fail++; $display("FAIL rstmid_drop: got req=%b state=%0d want req=0 state=0", dmem.dmem_req, dut.state_q);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    dmem.dmem_rvalid = 1'b1; dmem.dmem_rdata = 32'hDEAD_BEEF; dmem.dmem_err = 1'b1;
    @(posedge clk); #1;
    dmem.dmem_rvalid = 1'b0; dmem.dmem_err = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({load_data, bus_err, lsu_stall} !== 34'h0) begin
      n_fail++; $display("FAIL rstmid_late: got ld=%h err=%b stall=%b want 0", load_data, bus_err, lsu_stall);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_misalign;
    res_t r;
    preload(0, 32'hCAFE_F00D);
    run_op(1'b0, F3_LW, 32'h1001, 32'h0, 0, 0, 1'b0, -1, r);
`ifdef LSU_MISALIGN_CHECK_EN
    n_tests++;
    if ({r.saw_req, r.mis} !== 2'b01) begin n_fail++; $display("FAIL mis_flags: got req,mis=%b want 01", {r.saw_req, r.mis}); end
    n_tests++;
    if (r.ld !== 32'h0 || r.stall_n !== 1) begin
      n_fail++; $display("FAIL mis_result: got ld=%h stall=%0d want ld=0 stall=1", r.ld, r.stall_n);
    end
`else
    n_tests++;
    if ({r.saw_req, r.mis, r.addr} !== {2'b10, 32'h1000}) begin
      n_fail++; $display("FAIL mis_bus: got req=%b mis=%b addr=%h want req=1 mis=0 addr=00001000", r.saw_req, r.mis, r.addr);
    end
    n_tests++;
    if (r.ld !== 32'hCAFE_F00D || r.stall_n !== 3) begin
      n_fail++; $display("FAIL mis_result: got ld=%h stall=%0d want ld=cafef00d stall=3", r.ld, r.stall_n);
    end
`endif
  endtask

  task automatic test_back_to_back;
    res_t r1, r2;
    preload(2, 32'h9A34_80FF);
    run_op(1'b0, F3_LH, 32'h1008, 32'h0, 0, 0, 1'b0, -1, r1);
    run_op(1'b0, F3_LBU, 32'h100B, 32'h0, 0, 0, 1'b0, -1, r2);
    n_tests++;
    if (r1.ld !== 32'hFFFF_80FF) begin n_fail++; $display("FAIL b2b_first: got %h want ffff80ff", r1.ld); end
    n_tests++;
    if (r2.ld !== 32'h0000_009A || r2.stall_n !== 3) begin
      n_fail++; $display("FAIL b2b_second: got ld=%h stall=%0d want ld=0000009a stall=3", r2.ld, r2.stall_n);
    end
  endtask

  task automatic test_random;
    res_t r;
    logic [31:0] ld_model, a, eff, wd;
    logic [2:0]  f3;
    logic        w, e, mis_exp;
    int          sz, gd, rd, stall_exp;
    ld_model = 32'h0000_009A;
    for (int i = 0; i < 16; i++) preload(i, $urandom);
    for (int n = 0; n < 60; n++) begin
      w  = 1'($urandom_range(0, 1));
      sz = int'($urandom_range(0, 2));
      f3 = 3'(sz);
      if (!w && sz != 2 && $urandom_range(0, 1) == 1) f3[2] = 1'b1;
      a  = 32'h3000 | 32'($urandom_range(0, 63));
      wd = $urandom;
      gd = int'($urandom_range(0, 3));
      rd = int'($urandom_range(0, 3));
      e  = ($urandom_range(0, 7) == 0);
      eff = (sz == 0) ? a : (sz == 1) ? (a & ~32'h1) : (a & ~32'h3);
      mis_exp = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
      mis_exp = (eff != a);
`endif
      if (mis_exp) ld_model = 32'h0;
      else if (w) ref_store(sz, eff, wd);
      else ld_model = ref_load(f3, eff);
      stall_exp = mis_exp ? 1 : 3 + gd + rd;
      run_op(w, f3, a, wd, gd, rd, e, -1, r);
      n_tests++;
      if (r.ld !== ld_model) begin
        n_fail++; $display("FAIL rnd_data[%0d]: we=%b f3=%b a=%h got %h want %h", n, w, f3, a, r.ld, ld_model);
      end
      n_tests++;
      if (r.stall_n !== stall_exp) begin
        n_fail++; $display("FAIL rnd_stall[%0d]: gd=%0d rd=%0d got %0d want %0d", n, gd, rd, r.stall_n, stall_exp);
      end
      n_tests++;
      if ({r.berr, r.mis} !== {e & ~mis_exp, mis_exp}) begin
        n_fail++; $display("FAIL rnd_flags[%0d]: got err,mis=%b want %b", n, {r.berr, r.mis}, {e & ~mis_exp, mis_exp});
      end
    end
    for (int i = 0; i < 16; i++) begin
      n_tests++;
      if (bmem[i] !== {rmem[4*i+3], rmem[4*i+2], rmem[4*i+1], rmem[4*i]}) begin
        n_fail++; $display("FAIL rnd_mem[%0d]: got %h want %h", i, bmem[i],
                           {rmem[4*i+3], rmem[4*i+2], rmem[4*i+1], rmem[4*i]});
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_lb();
    test_sh();
    test_lw_gnt_delay();
    test_flush_resp();
    test_bus_err();
    test_reset_mid();
    test_misalign();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_lsu.md
# mem_lsu

Load/store unit for the MEM stage of the RV32 five-stage pipeline. It takes the memory-op fields latched in EX/MEM and runs one request/grant/response transaction per access on the data-memory bus. It holds the pipeline while the bus is busy and delivers aligned, sign/zero-extended load data to the MEM/WB register. It is the producer side of the MEM/WB `mem_data` path.

## Interface
Parameters:
- `ADDR_W`, 32, byte-address width
- `DATA_W`, 32, bus data width (fixed 32; other values unsupported)

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `req_valid`  in  1  EX/MEM holds a load or store (`mem_read | mem_write`)
- `mem_write`  in  1  1 = store, 0 = load
- `funct3`  in  3  RV32I size/sign: LB 000, LH 001, LW 010, LBU 100, LHU 101, SB 000, SH 001, SW 010
- `addr`  in  32  effective byte address (ALU result)
- `wdata`  in  32  store data (rs2)
- `flush`  in  1  kill the op currently in MEM
- `pipe_advance`  in  1  MEM/WB `enable` this cycle
- `dmem_req`  out  1  bus request
- `dmem_we`  out  1  bus write
- `dmem_be`  out  4  byte enables
- `dmem_addr`  out  32  word address, bits [1:0] = 0
- `dmem_wdata`  out  32  lane-replicated store data
- `dmem_gnt`  in  1  request accepted
- `dmem_rvalid`  in  1  response valid (loads and stores)
- `dmem_rdata`  in  32  read data
- `dmem_err`  in  1  bus error, qualified by `dmem_rvalid`
- `lsu_stall`  out  1  hold IF..MEM stages
- `load_data`  out  32  formatted load result, to MEM/WB `mem_data_in`
- `bus_err`  out  1  1-cycle pulse, access faulted
- `misaligned`  out  1  1-cycle pulse, misaligned access (macro-dependent)

## Operation
- States: IDLE, REQ, RESP.
- IDLE: if `req_valid && !done_q && !flush`, latch `mem_write`/`funct3`/`addr[1:0]`/bus fields; go to REQ.
- REQ: `dmem_req`=1. Address, `we`, `be` and `wdata` stay stable until `dmem_gnt`. On `gnt`, go to RESP.
- RESP: wait for `dmem_rvalid`. On it:
  - capture formatted `dmem_rdata` into `load_data` (loads only; stores leave it unchanged)
  - pulse `bus_err` if `dmem_err`
  - set `done_q`; go to IDLE
- `done_q` clears when `pipe_advance`=1. This prevents re-issue of the same EX/MEM op.
- `lsu_stall` = (state != IDLE) || (`req_valid && !done_q && !flush`).
- Byte enables:
  - SB: `0001 << addr[1:0]`
  - SH: `0011 << {addr[1],0}`
  - SW: `1111`
- Store data: `wdata[7:0]` replicated ×4 for SB, `wdata[15:0]` ×2 for SH, raw for SW.
- Load formatting: `rdata >> 8*offset`, then:
  - LB/LH: sign-extend from bit 7/15
  - LBU/LHU: zero-extend
  - LW: passed unchanged
- `flush`:
  - In IDLE, no request is issued.
  - In REQ/RESP the transaction runs to completion, because the bus cannot withdraw a request. A `discard` flag is set. When `rvalid` arrives, `load_data`, `done_q` and `bus_err` are not updated. A flushed store is still written to memory.
- Back-to-back ops: the next op issues the cycle after `done_q` clears.

## Timing
- Reset values:
  - state = IDLE
  - `dmem_req`, `dmem_we` = 0
  - `dmem_be` = 0
  - `dmem_addr`, `dmem_wdata`, `load_data` = 0
  - `lsu_stall`, `bus_err`, `misaligned`, `done_q`, `discard` = 0
- Reset mid-transaction: return to IDLE and drop `dmem_req` immediately. A late response after reset is ignored.
- Latency with zero-wait bus (`gnt` in first REQ cycle, `rvalid` next cycle): op seen in cycle 0, REQ in cycle 1, RESP in cycle 2, `load_data` valid and `lsu_stall`=0 in cycle 3. The stall is 3 cycles.
- Each cycle of `gnt` or `rvalid` delay adds one stall cycle.
- `dmem_*` outputs are registered; there is no combinational path from `addr` to the bus.

## Configuration
- `LSU_MISALIGN_CHECK_EN` defined: detection is active.
  - Misaligned cases are LH/LHU/SH with `addr[0]`=1, and LW/SW with `addr[1:0]`≠0.
  - No bus request is issued.
  - `misaligned` pulses for 1 cycle and `load_data` = 0.
  - `done_q` is set; stall lasts 1 cycle.
- Undefined: `misaligned` is tied 0. Halfword accesses ignore `addr[0]`, word accesses ignore `addr[1:0]`, and the access proceeds aligned.

## Structure
- `riscv_pkg`:
  - `lsu_state_t` enum
  - `funct3` constants (`F3_LB`..`F3_LHU`)
  - `lsu_size_t`
- Sub-module `lsu_load_align`: combinational lane shift plus sign/zero extension, from (`rdata`, `offset`, `funct3`) to 32-bit result.

## Test plan
- LB at `addr`=0x1003, `rdata`=0x80FF_1234, zero-wait bus -> `be`=1111 read, `load_data`=0xFFFF_FF80 in cycle 3, `lsu_stall` high cycles 0–2.
- SH at `addr`=0x2002, `wdata`=0xABCD_5678 -> `dmem_be`=1100, `dmem_wdata`=0x5678_5678, `dmem_addr`=0x2000, `we`=1.
- LW with `gnt` delayed 3 cycles -> `dmem_addr`/`be` stable while `req`=1, stall extends by 3, `load_data`=`rdata`.
- `flush` asserted in RESP, then `rvalid` with `rdata`=0xDEAD_BEEF -> `load_data` unchanged, `done_q`=0, no `bus_err`.
- `rvalid` with `dmem_err`=1 -> `bus_err` 1-cycle pulse; `rst_n` low during REQ -> `dmem_req`=0 same cycle, state IDLE.
- LW at 0x1001 with `LSU_MISALIGN_CHECK_EN` -> no `dmem_req`, `misaligned` pulse, `load_data`=0; without the macro -> word read at 0x1000.
